// File: rtl/clause_image_loader_pkg.sv
// Shared types for the clause image loader: record tags, loader states and the
// node/dummy/literal payload formats seen by the BCP lookup top.
`ifndef NUM_ENGINE
`define NUM_ENGINE 2
`endif

package clause_image_loader_pkg;

   typedef logic [15:0] lit_t;

   typedef struct packed {
      logic [7:0] slot;
      lit_t       lit;
   } dummy_entry_t;

   typedef struct packed {
      lit_t lit_a;
      lit_t lit_b;
      lit_t lit_c;
   } node_t;

   typedef enum logic [2:0] {
      REC_CLAUSE  = 3'd0,
      REC_PTR     = 3'd1,
      REC_ENG_END = 3'd2,
      REC_UNIT    = 3'd3,
      REC_EOF     = 3'd4
   } rec_type_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_UNITS,
      ST_DONE,
      ST_ERR
   } ld_state_t;

   localparam int PAY_W = $bits(node_t);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/clause_image_loader_rec_decode.sv
// Per-state record decoder: flags which record kind is being offered and
// whether its tag is illegal in the current state (undefined tags included).
module clause_image_loader_rec_decode
   import clause_image_loader_pkg::*;
(
   input  ld_state_t state,
   input  rec_type_t rec_type,
   output logic      acc_clause,
   output logic      acc_ptr,
   output logic      acc_eng_end,
   output logic      acc_unit,
   output logic      acc_eof,
   output logic      acc_bad
);

   always_comb begin
      acc_clause  = 1'b0;
      acc_ptr     = 1'b0;
      acc_eng_end = 1'b0;
      acc_unit    = 1'b0;
      acc_eof     = 1'b0;
      acc_bad     = 1'b0;
      case (state)
         ST_LOAD: begin
            case (rec_type)
               REC_CLAUSE:  acc_clause  = 1'b1;
               REC_PTR:     acc_ptr     = 1'b1;
               REC_ENG_END: acc_eng_end = 1'b1;
               default:     acc_bad     = 1'b1;
            endcase
         end
         ST_UNITS: begin
            case (rec_type)
               REC_UNIT: acc_unit = 1'b1;
               REC_EOF:  acc_eof  = 1'b1;
               default:  acc_bad  = 1'b1;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/clause_image_loader.sv
// Loads one clause database image from a tagged record stream into the lookup
// top and holds the engines halted until done. LOADER_STATS_EN adds record counters.
//
// state    | meaning
// IDLE     | waiting for start, stream not accepted
// LOAD     | clauses, dummy pointers and engine-end markers
// UNITS    | initial unit literals until EOF
// DONE     | image complete, engines released
// ERR      | malformed image, stream drained, leave only by reset
module clause_image_loader
   import clause_image_loader_pkg::*;
#(
   parameter int NUM_ENG     = `NUM_ENGINE,
   parameter int MAX_CLAUSES = 256,
   parameter int CNT_W       = $clog2(MAX_CLAUSES + 1),
   localparam int ENG_W      = $clog2(NUM_ENG + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             rec_valid,
   output logic             rec_ready,
   input  rec_type_t        rec_type,
   input  logic [PAY_W-1:0] rec_payload,
   output node_t            node_in,
   output logic             node_in_valid,
   output dummy_entry_t     dummy_ptr,
   output logic             dummy_ptr_valid,
   output logic             change_eng,
   output lit_t             mem2uca,
   output logic             mem2uca_valid,
   output logic             mem2uca_done,
   output logic             halt,
   output logic             load_done,
   output logic             load_err,
   output logic [ENG_W-1:0] eng_idx
`ifdef LOADER_STATS_EN
   ,
   output logic [15:0]      stat_clauses,
   output logic [15:0]      stat_ptrs,
   output logic [15:0]      stat_units
`endif
);

   localparam logic [ENG_W-1:0] ENG_LAST = ENG_W'(NUM_ENG);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CLAUSES);

   ld_state_t        state;
   logic [CNT_W-1:0] clause_cnt;
   logic [ENG_W-1:0] eng_next;
   logic             accept;
   logic             start_ok;
   logic             clause_ovf;
   logic             acc_clause, acc_ptr, acc_eng_end, acc_unit, acc_eof, acc_bad;

   clause_image_loader_rec_decode u_loader_rec_decode (
      .state       (state),
      .rec_type    (rec_type),
      .acc_clause  (acc_clause),
      .acc_ptr     (acc_ptr),
      .acc_eng_end (acc_eng_end),
      .acc_unit    (acc_unit),
      .acc_eof     (acc_eof),
      .acc_bad     (acc_bad)
   );

   assign rec_ready  = (state == ST_LOAD) || (state == ST_UNITS) || (state == ST_ERR);
   assign halt       = (state != ST_DONE);
   assign load_done  = (state == ST_DONE);
   assign load_err   = (state == ST_ERR);
   assign accept     = rec_valid && rec_ready;
   assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign eng_next   = eng_idx + 1'b1;
   assign clause_ovf = (clause_cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         clause_cnt      <= '0;
         eng_idx         <= '0;
         node_in         <= '0;
         node_in_valid   <= 1'b0;
         dummy_ptr       <= '0;
         dummy_ptr_valid <= 1'b0;
         change_eng      <= 1'b0;
         mem2uca         <= '0;
         mem2uca_valid   <= 1'b0;
         mem2uca_done    <= 1'b0;
      end else begin
         node_in_valid   <= 1'b0;
         dummy_ptr_valid <= 1'b0;
         change_eng      <= 1'b0;
         mem2uca_valid   <= 1'b0;
         mem2uca_done    <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_LOAD;
                  clause_cnt <= '0;
                  eng_idx    <= '0;
               end
            end
            ST_LOAD, ST_UNITS: begin
               if (accept) begin
                  // an offending record produces no pulse of its own
                  if (acc_bad || (acc_clause && clause_ovf)) begin
                     state <= ST_ERR;
                  end else if (acc_clause) begin
                     node_in       <= node_t'(rec_payload);
                     node_in_valid <= 1'b1;
                     clause_cnt    <= clause_cnt + 1'b1;
                  end else if (acc_ptr) begin
                     dummy_ptr       <= rec_payload[$bits(dummy_entry_t)-1:0];
                     dummy_ptr_valid <= 1'b1;
                  end else if (acc_eng_end) begin
                     eng_idx    <= eng_next;
                     clause_cnt <= '0;
                     if (eng_next < ENG_LAST) change_eng <= 1'b1;
                     else                     state      <= ST_UNITS;
                  end else if (acc_unit) begin
                     mem2uca       <= rec_payload[$bits(lit_t)-1:0];
                     mem2uca_valid <= 1'b1;
                  end else if (acc_eof) begin
                     mem2uca_done <= 1'b1;
                     state        <= ST_DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef LOADER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_clauses <= '0;
         stat_ptrs    <= '0;
         stat_units   <= '0;
      end else if (start_ok) begin
         stat_clauses <= '0;
         stat_ptrs    <= '0;
         stat_units   <= '0;
      end else if (accept) begin
         if (acc_clause && !clause_ovf) stat_clauses <= sat_inc16(stat_clauses);
         if (acc_ptr)                   stat_ptrs    <= sat_inc16(stat_ptrs);
         if (acc_unit)                  stat_units   <= sat_inc16(stat_units);
      end
   end
`endif

endmodule
